// File: rtl/ritc_bitslip_align_ctrl.sv
// rtl/ritc_bitslip_align_ctrl.sv - training-pattern bitslip alignment sequencer for the RITC datapath
`timescale 1ns/1ps

module ritc_bitslip_align_ctrl #(
  parameter logic [3:0] PATTERN       = 4'b0011,
  parameter int         MATCH_COUNT   = 4,
  parameter int         SETTLE_CYCLES = 16,
  parameter int         MAX_SLIPS     = 8
) (
  input  logic         user_clk_i,
  input  logic         rst_n_i,
  input  logic         start_i,
  input  logic [287:0] ch_data_i,
  output logic         user_sel_o,
  output logic         user_wr_o,
  output logic [31:0]  user_dat_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [71:0]  lock_o,
  output logic [71:0]  fail_o,
  output logic         err_o
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam int LW = $clog2(MAX_SLIPS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_SLIP,
    S_NEXT,
    S_DONE
  } state_t;

  state_t          state;
  logic [2:0]      ch_idx;
  logic [3:0]      bit_idx;
  logic [SW-1:0]   settle_cnt;
  logic [MW-1:0]   match_cnt;
  logic [MW-1:0]   miss_cnt;
  logic [LW-1:0]   slip_cnt;

  logic [287:0]    d_meta;
  logic [287:0]    d_sync;
  logic [47:0]     ch_word;
  logic [11:0]     q0, q1, q2, q3;
  logic [3:0]      nib;
  logic [6:0]      lane_idx;

  // Two-flop capture of the SYSCLK-domain datapath outputs; torn words are
  // absorbed by the consecutive match/miss rule rather than by handshaking.
  always_ff @(posedge user_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      d_meta <= '0;
      d_sync <= '0;
    end else begin
      d_meta <= ch_data_i;
      d_sync <= d_meta;
    end
  end

  // Select the 48-bit word of the channel currently being trained.
  always_comb begin
    ch_word = '0;
    for (int c = 0; c < 6; c++) begin
      if (ch_idx == 3'(c)) begin
        ch_word = d_sync[48*c +: 48];
      end
    end
  end

  // Each channel word is four 12-bit sample planes, earliest sample at the bottom.
  assign q0  = ch_word[11:0];
  assign q1  = ch_word[23:12];
  assign q2  = ch_word[35:24];
  assign q3  = ch_word[47:36];
  assign nib = {q3[bit_idx], q2[bit_idx], q1[bit_idx], q0[bit_idx]};

  // Flat lane number 12*ch + bit, built from shifts to stay in 7 bits.
  assign lane_idx = {1'b0, ch_idx, 3'b000} + {2'b00, ch_idx, 2'b00} + {3'b000, bit_idx};

  // Alignment sequencer: settle, sample, slip or advance, one lane at a time.
  always_ff @(posedge user_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      ch_idx     <= '0;
      bit_idx    <= '0;
      settle_cnt <= '0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      slip_cnt   <= '0;
      user_sel_o <= 1'b0;
      user_wr_o  <= 1'b0;
      user_dat_o <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      lock_o     <= '0;
      fail_o     <= '0;
      err_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            lock_o     <= '0;
            fail_o     <= '0;
            err_o      <= 1'b0;
            ch_idx     <= '0;
            bit_idx    <= '0;
            slip_cnt   <= '0;
            settle_cnt <= '0;
            busy_o     <= 1'b1;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
            settle_cnt <= '0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
            state      <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        S_SAMPLE: begin
          if (nib == PATTERN) begin
            miss_cnt <= '0;
            if (match_cnt == MW'(MATCH_COUNT - 1)) begin
              lock_o[lane_idx] <= 1'b1;
              state            <= S_NEXT;
            end else begin
              match_cnt <= match_cnt + MW'(1);
            end
          end else begin
            match_cnt <= '0;
            if (miss_cnt == MW'(MATCH_COUNT - 1)) begin
              if (slip_cnt == LW'(MAX_SLIPS)) begin
                fail_o[lane_idx] <= 1'b1;
                state            <= S_NEXT;
              end else begin
                user_sel_o <= 1'b1;
                user_wr_o  <= 1'b1;
                user_dat_o <= {25'b0, ch_idx, bit_idx};
                state      <= S_SLIP;
              end
            end else begin
              miss_cnt <= miss_cnt + MW'(1);
            end
          end
        end
        S_SLIP: begin
          user_sel_o <= 1'b0;
          user_wr_o  <= 1'b0;
          if (slip_cnt != LW'(MAX_SLIPS)) begin
            slip_cnt <= slip_cnt + LW'(1);
          end
          state <= S_SETTLE;
        end
        S_NEXT: begin
          slip_cnt <= '0;
          if (bit_idx == 4'd11) begin
            if (ch_idx == 3'd5) begin
              state <= S_DONE;
            end else begin
              bit_idx <= '0;
              ch_idx  <= ch_idx + 3'd1;
              state   <= S_SETTLE;
            end
          end else begin
            bit_idx <= bit_idx + 4'd1;
            state   <= S_SETTLE;
          end
        end
        S_DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          err_o  <= |fail_o;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ritc_bitslip_align_ctrl.sv
// tb/tb_ritc_bitslip_align_ctrl.sv - directed bench with behavioural lane-walk model for ritc_bitslip_align_ctrl
`timescale 1ns/1ps

module tb_ritc_bitslip_align_ctrl;

  localparam logic [3:0] PAT = 4'b0011;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [287:0] ch_data = '0;
  logic         user_sel, user_wr, busy, done, err;
  logic [31:0]  user_dat;
  logic [71:0]  lock, fail;

  ritc_bitslip_align_ctrl dut (
    .user_clk_i (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .ch_data_i  (ch_data),
    .user_sel_o (user_sel),
    .user_wr_o  (user_wr),
    .user_dat_o (user_dat),
    .busy_o     (busy),
    .done_o     (done),
    .lock_o     (lock),
    .fail_o     (fail),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic        chk_en = 1'b1;
  logic [3:0]  nibs [72];
  logic        tog_en = 1'b0;
  logic        tog = 1'b0;
  logic [6:0]  li;
  int          wr_cnt = 0;
  int          wr_bad = 0;
  int          done_cnt = 0;
  logic [31:0] wr_target = '0;

  // expected outputs produced by the lane-walk model
  logic         exp_sel = 1'b0, exp_wr = 1'b0, exp_busy = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
  logic [31:0]  exp_dat = '0;
  logic [71:0]  exp_lock = '0, exp_fail = '0;
  logic [287:0] h0 = '0, h1 = '0, h2 = '0;
  logic         m_abort = 1'b0;

  function automatic logic [287:0] pack_lanes();
    logic [287:0] d;
    logic [8:0]   idx;
    d = '0;
    for (int l = 0; l < 72; l++) begin
      idx = 9'(48 * (l / 12) + l % 12);
      d[idx]         = nibs[7'(l)][0];
      d[idx + 9'd12] = nibs[7'(l)][1];
      d[idx + 9'd24] = nibs[7'(l)][2];
      d[idx + 9'd36] = nibs[7'(l)][3];
    end
    return d;
  endfunction

  function automatic logic [3:0] lane_nib(input logic [287:0] d, input int l);
    logic [8:0] idx;
    idx = 9'(48 * (l / 12) + l % 12);
    return {d[idx + 9'd36], d[idx + 9'd24], d[idx + 9'd12], d[idx]};
  endfunction

  // one clock of the model: pulses drop, reset wipes everything, input history shifts
  task automatic tick();
    @(posedge clk);
    exp_done = 1'b0;
    exp_wr   = 1'b0;
    exp_sel  = 1'b0;
    if (!rst_n) begin
      exp_busy = 1'b0; exp_err = 1'b0; exp_dat = '0; exp_lock = '0; exp_fail = '0;
      h0 = '0; h1 = '0; h2 = '0;
      m_abort = 1'b1;
    end else begin
      h2 = h1; h1 = h0; h0 = ch_data;
    end
  endtask

  // a full pass expressed as a walk over the 72 lanes
  task automatic run_pass();
    int slips, match, miss;
    m_abort  = 1'b0;
    exp_busy = 1'b1; exp_lock = '0; exp_fail = '0; exp_err = 1'b0;
    for (int lane = 0; lane < 72; lane++) begin
      slips = 0;
      forever begin
        for (int i = 0; i < 16; i++) begin
          tick(); if (m_abort) return;
        end
        match = 0; miss = 0;
        while (match < 4 && miss < 4) begin
          tick(); if (m_abort) return;
          if (lane_nib(h2, lane) == PAT) begin match++; miss = 0; end
          else begin miss++; match = 0; end
        end
        if (match == 4) begin exp_lock[7'(lane)] = 1'b1; break; end
        if (slips == 8) begin exp_fail[7'(lane)] = 1'b1; break; end
        exp_sel = 1'b1; exp_wr = 1'b1;
        exp_dat = {25'b0, 3'(lane / 12), 4'(lane % 12)};
        tick(); if (m_abort) return;
        slips++;
      end
      tick(); if (m_abort) return;
    end
    tick(); if (m_abort) return;
    exp_done = 1'b1; exp_busy = 1'b0; exp_err = |exp_fail;
  endtask

  initial forever begin
    tick();
    if (rst_n && start) run_pass();
  end

  // datapath stand-in: a bitslip rotates the addressed lane one sample to the right
  initial forever begin
    @(negedge clk);
    if (user_wr) begin
      li = 7'(int'(user_dat[6:4]) * 12 + int'(user_dat[3:0]));
      if (li < 7'd72) nibs[li] = {nibs[li][0], nibs[li][3:1]};
    end
    if (tog_en) begin
      tog = ~tog;
      nibs[15] = tog ? PAT : 4'b0000;
    end
    ch_data = pack_lanes();
  end

  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
    if (user_wr) begin
      wr_cnt++;
      if (user_dat !== wr_target) wr_bad++;
    end
  end

  // cycle-by-cycle comparison against the model (err_o only meaningful when idle)
  initial forever begin
    logic [180:0] act, exv;
    @(negedge clk);
    if (chk_en) begin
      act = {user_sel, user_wr, user_dat, busy, done, exp_busy ? 1'b0 : err, lock, fail};
      exv = {exp_sel, exp_wr, exp_dat, exp_busy, exp_done, exp_busy ? 1'b0 : exp_err, exp_lock, exp_fail};
      checks++;
      if (act !== exv) begin
        errors++;
        $display("FAIL model_cmp t=%0t got=%h want=%h", $time, act, exv);
      end
    end
  end

  task automatic checki(input string name, input int act, input int exv);
    checks++;
    if (act !== exv) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exv);
    end
  endtask

  task automatic checkv(input string name, input logic [71:0] act, input logic [71:0] exv);
    checks++;
    if (act !== exv) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exv);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout got=0 want=1 cycles=%0d", n);
    end
  endtask

  task automatic set_all();
    for (int l = 0; l < 72; l++) nibs[7'(l)] = PAT;
  endtask

  task automatic clr_counts(input logic [31:0] target);
    wr_cnt = 0; wr_bad = 0; done_cnt = 0; wr_target = target;
  endtask

  localparam logic [71:0] ALL1 = {72{1'b1}};

  initial begin
    int n;
    set_all();
    repeat (3) @(negedge clk);
    checki("rst_ctrl", int'({user_sel, user_wr, busy, done, err}), 0);
    checki("rst_dat", int'(user_dat), 0);
    checkv("rst_lock", lock, '0);
    checkv("rst_fail", fail, '0);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // all lanes already aligned
    clr_counts(32'h0);
    pulse_start();
    wait_done(4000, n);
    checki("t1_done_cycles", n, 72 * 21 + 1);
    checki("t1_writes", wr_cnt, 0);
    checkv("t1_lock", lock, ALL1);
    checkv("t1_fail", fail, '0);
    checki("t1_err", int'(err), 0);
    repeat (5) @(negedge clk);

    // lane (2,5) needs three right rotations
    nibs[29] = 4'b1001;
    clr_counts(32'h25);
    pulse_start();
    wait_done(4000, n);
    checki("t2_done_cycles", n, 1513 + 3 * 21);
    checki("t2_writes", wr_cnt, 3);
    checki("t2_bad_dat", wr_bad, 0);
    checki("t2_lock29", int'(lock[29]), 1);
    checkv("t2_lock", lock, ALL1);
    repeat (5) @(negedge clk);

    // lane (0,0) stuck low gives up after eight slips
    set_all();
    nibs[0] = 4'b0000;
    clr_counts(32'h00);
    pulse_start();
    wait_done(4000, n);
    checki("t3_done_cycles", n, 1513 + 8 * 21);
    checki("t3_writes", wr_cnt, 8);
    checki("t3_bad_dat", wr_bad, 0);
    checkv("t3_fail", fail, 72'h1);
    checki("t3_lock0", int'(lock[0]), 0);
    checki("t3_err", int'(err), 1);
    repeat (5) @(negedge clk);

    // lane (1,3) alternates right/wrong, then settles on the pattern
    set_all();
    clr_counts(32'hFFFF_FFFF);
    tog_en = 1'b1;
    pulse_start();
    repeat (600) @(negedge clk);
    checki("t4_mid_writes", wr_cnt, 0);
    checki("t4_mid_busy", int'(busy), 1);
    checki("t4_mid_lock14", int'(lock[14]), 1);
    checki("t4_mid_lf15", int'({lock[15], fail[15]}), 0);
    tog_en = 1'b0;
    nibs[15] = PAT;
    wait_done(4000, n);
    checkv("t4_lock", lock, ALL1);
    checkv("t4_fail", fail, '0);
    checki("t4_writes", wr_cnt, 0);
    repeat (5) @(negedge clk);

    // reset during the slip of lane (3,7), then a clean restart from lane (0,0)
    set_all();
    nibs[43] = 4'b0000;
    clr_counts(32'h37);
    pulse_start();
    n = 0;
    while (!user_wr && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checki("t5_slip_seen", int'(user_wr), 1);
    checki("t5_slip_dat", int'(user_dat), 32'h37);
    checki("t5_pre_lock0", int'(lock[0]), 1);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checki("t5_rst_wr", int'({user_wr, user_sel}), 0);
    checki("t5_rst_busy", int'(busy), 0);
    checkv("t5_rst_lock", lock, '0);
    checkv("t5_rst_fail", fail, '0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    nibs[43] = PAT;
    nibs[0]  = 4'b1001;
    clr_counts(32'h00);
    pulse_start();
    n = 0;
    while (!user_wr && n < 200) begin
      @(negedge clk);
      n++;
    end
    checki("t5_first_wr_cycle", n, 20);
    checki("t5_first_wr_dat", int'(user_dat), 0);
    wait_done(4000, n);
    checkv("t5_lock", lock, ALL1);
    checki("t5_writes", wr_cnt, 3);
    repeat (5) @(negedge clk);

    // start while busy is ignored
    set_all();
    clr_counts(32'h0);
    pulse_start();
    repeat (200) @(negedge clk);
    pulse_start();
    wait_done(4000, n);
    checki("t6_done_cycles", n + 202, 1513);
    repeat (30) @(negedge clk);
    checki("t6_done_count", done_cnt, 1);
    checki("t6_idle", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
